// File: rtl/mac_tx_scheduler.sv
// mac_tx_scheduler: FIFO-buffered response words issued to mac_tx as start pulses separated by a fixed hold-off
module mac_tx_scheduler #(
  parameter int DEPTH = 8,
  parameter int HOLDOFF = 336
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [15:0]              data,
  output logic                     start,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLDOFF) + 1;
  typedef enum logic [1:0] {IDLE, START, HOLD} state_t;
  state_t          state_q;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     occ_q, occ_d;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     data_q;
  logic            start_q, busy_q, ovf_q;
  logic            push, pop, active_d;
  assign in_ready  = occ_q != (AW+1)'(DEPTH);
  assign push      = in_valid && in_ready;
  assign pop       = state_q == IDLE && occ_q != '0;
  assign occ_d     = occ_q + (AW+1)'(push) - (AW+1)'(pop);
  assign active_d  = pop || state_q == START || (state_q == HOLD && cnt_q != '0);
  assign data      = data_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign occupancy = occ_q;
  assign overflow  = ovf_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_data;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      occ_q    <= occ_d;
      ovf_q    <= ovf_q | (in_valid & ~in_ready);
      busy_q   <= active_d | (occ_d != '0);
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      data_q  <= '0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (pop) begin
          data_q  <= mem_q[rd_ptr_q];
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          cnt_q   <= CW'(HOLDOFF - 1);
          state_q <= HOLD;
        end
        HOLD: if (cnt_q == '0) state_q <= IDLE;
              else cnt_q <= cnt_q - CW'(1);
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mac_tx_scheduler.sv
// tb_mac_tx_scheduler: directed self-checking bench for mac_tx_scheduler
module tb_mac_tx_scheduler;
  localparam int DEPTH = 8;
  localparam int H = 336;
  localparam int P = H + 2;
  logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, start, busy, overflow;
  logic [15:0] data;
  logic [3:0] occupancy;
  int checks = 0, failures = 0, cyc = 0, max_occ = 0;
  int starts[$], chg[$];
  logic [15:0] sdata[$];
  logic [15:0] prev_data = '0;
  mac_tx_scheduler #(.DEPTH(DEPTH), .HOLDOFF(H)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .start(start), .busy(busy), .occupancy(occupancy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (start === 1'b1) begin
      starts.push_back(cyc);
      sdata.push_back(data);
    end
    if (data !== prev_data) chg.push_back(cyc);
    prev_data = data;
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic assert_reset();
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
  endtask
  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    starts.delete();
    sdata.delete();
    chg.delete();
    max_occ = 0;
    prev_data = data;
  endtask
  task automatic do_reset();
    assert_reset();
    release_reset();
  endtask
  task automatic wait_frames(input int n, input int max);
    for (int i = 0; i < max && starts.size() < n; i++) step();
  endtask
  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy !== 1'b0; i++) step();
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (data !== 16'h0) begin failures++; $display("FAIL reset_data: got %h want 0000", data); end
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask
  task automatic test_single();
    int t;
    do_reset();
    repeat (7) step();
    t = cyc;
    in_valid = 1'b1;
    in_data = 16'h5678;
    step();
    in_valid = 1'b0;
    checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_on: got %b want 1", busy); end
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL single_start_early: got %b want 0", start); end
    step();
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL single_start: got %b want 1", start); end
    checks++; if (data !== 16'h5678) begin failures++; $display("FAIL single_data: got %h want 5678", data); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL single_occ_pop: got %0d want 0", occupancy); end
    step();
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL single_start_width: got %b want 0", start); end
    while (cyc < t + 338) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_last_hold: got %b want 1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_drop: got %b want 0", busy); end
    repeat (2000) step();
    checks++; if (starts.size() !== 1) begin failures++; $display("FAIL single_pulse_count: got %0d want 1", starts.size()); end
    checks++; if (data !== 16'h5678) begin failures++; $display("FAIL single_data_hold: got %h want 5678", data); end
    checks++; if (chg.size() !== 1 || chg[0] !== t + 2) begin failures++; $display("FAIL single_data_change: got %0d changes want 1 at cycle %0d", chg.size(), t + 2); end
  endtask
  task automatic test_burst();
    int t;
    do_reset();
    t = cyc;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 16'(i);
      step();
    end
    in_valid = 1'b0;
    wait_frames(3, 3 * P + 10);
    checks++;
    if (starts.size() !== 3) begin
      failures++; $display("FAIL burst_pulse_count: got %0d want 3", starts.size());
    end else begin
      checks++; if (starts[0] !== t + 2) begin failures++; $display("FAIL burst_first_start: got cycle %0d want %0d", starts[0], t + 2); end
      for (int i = 0; i < 3; i++) begin
        checks++; if (sdata[i] !== 16'(i + 1)) begin failures++; $display("FAIL burst_data%0d: got %h want %h", i, sdata[i], 16'(i + 1)); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++; if (starts[i] - starts[i-1] !== P) begin failures++; $display("FAIL burst_spacing%0d: got %0d want %0d", i, starts[i] - starts[i-1], P); end
      end
      checks++;
      if (chg.size() !== 3 || chg[0] !== starts[0] || chg[1] !== starts[1] || chg[2] !== starts[2]) begin
        failures++; $display("FAIL burst_data_stable: got %0d data changes want 3 at start pulses", chg.size());
      end
    end
    wait_idle(P + 10);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_busy_end: got %b want 0", busy); end
  endtask
  task automatic test_overflow();
    int bad;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'hA000 + 16'(i);
      if (i == 8) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready_before_full: got %b want 1", in_ready); end
      end
      if (i == 9) begin
        checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL ovf_occ_full: got %0d want 8", occupancy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready_full: got %b want 0", in_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_flag_early: got %b want 0", overflow); end
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag_set: got %b want 1", overflow); end
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL ovf_occ_after: got %0d want 8", occupancy); end
    wait_frames(9, 9 * P + 10);
    wait_idle(P + 10);
    repeat (20) step();
    checks++;
    if (starts.size() !== 9) begin
      failures++; $display("FAIL ovf_frame_count: got %0d want 9", starts.size());
    end else begin
      bad = -1;
      for (int i = 0; i < 9; i++) if (bad < 0 && sdata[i] !== 16'hA000 + 16'(i)) bad = i;
      checks++; if (bad !== -1) begin failures++; $display("FAIL ovf_order: frame %0d got %h want %h", bad, sdata[bad], 16'hA000 + 16'(bad)); end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask
  task automatic test_collision();
    int t;
    do_reset();
    t = cyc;
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 16'hB000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    while (cyc < t + 339) step();
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL coll_occ_full: got %0d want 8", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL coll_ready_full: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    step();
    checks++; if (occupancy !== 4'd7) begin failures++; $display("FAIL coll_occ_after_pop: got %0d want 7", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL coll_ready_after_pop: got %b want 1", in_ready); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL coll_overflow: got %b want 1", overflow); end
    in_data = 16'hC0DE;
    step();
    in_valid = 1'b0;
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL coll_occ_refill: got %0d want 8", occupancy); end
    checks++;
    if (starts.size() !== 2 || starts[1] !== t + 340 || sdata[1] !== 16'hB001) begin
      failures++; $display("FAIL coll_second_frame: got %0d pulses want 2 with B001 at cycle %0d", starts.size(), t + 340);
    end
    wait_frames(10, 9 * P + 10);
    wait_idle(P + 10);
    checks++;
    if (sdata.size() !== 10 || sdata[9] !== 16'hC0DE || sdata[8] !== 16'hB008) begin
      failures++; $display("FAIL coll_tail: got %0d frames want 10 ending B008,C0DE", sdata.size());
    end
  endtask
  task automatic test_reset_mid_hold();
    int t;
    do_reset();
    t = cyc;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'hD000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    while (cyc < t + 102) step();
    checks++; if (occupancy !== 4'd4) begin failures++; $display("FAIL rst_occ_before: got %0d want 4", occupancy); end
    checks++; if (data !== 16'hD000) begin failures++; $display("FAIL rst_data_before: got %h want d000", data); end
    assert_reset();
    checks++; if (data !== 16'h0) begin failures++; $display("FAIL rst_async_data: got %h want 0000", data); end
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL rst_async_start: got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL rst_async_occ: got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready: got %b want 1", in_ready); end
    release_reset();
    repeat (500) step();
    checks++; if (starts.size() !== 0) begin failures++; $display("FAIL rst_no_pulse: got %0d pulses want 0", starts.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    in_valid = 1'b1;
    in_data = 16'h1234;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL rst_new_start: got %b want 1", start); end
    checks++; if (data !== 16'h1234) begin failures++; $display("FAIL rst_new_data: got %h want 1234", data); end
  endtask
  task automatic test_wrap();
    int bad;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data = 16'hE000 + 16'(i);
      step();
      in_valid = 1'b0;
      repeat (319) step();
    end
    wait_frames(20, 3 * P);
    wait_idle(P + 10);
    checks++;
    if (starts.size() !== 20) begin
      failures++; $display("FAIL wrap_frame_count: got %0d want 20", starts.size());
    end else begin
      bad = -1;
      for (int i = 0; i < 20; i++) if (bad < 0 && sdata[i] !== 16'hE000 + 16'(i)) bad = i;
      checks++; if (bad !== -1) begin failures++; $display("FAIL wrap_order: frame %0d got %h want %h", bad, sdata[bad], 16'hE000 + 16'(bad)); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_overflow: got %b want 0", overflow); end
    checks++; if (max_occ > 3) begin failures++; $display("FAIL wrap_max_occ: got %0d want at most 3", max_occ); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_collision();
    test_reset_mid_hold();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
